// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one data-memory port between two masters.
// It also decodes addresses and runs a watchdog, so a bad address or a dead memory returns an error response.
module mem_arbiter #(
    parameter int MEM_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    localparam int          TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [TW-1:0]   timer_r;
    logic            any_req_s;
    logic            winner_s;
    logic            addr_ok_s;
    logic            timeout_s;
    logic [31:0]     win_addr_s;
    logic [31:0]     win_wdata_s;
    logic [3:0]      win_wstrb_s;
    logic            resp_valid_s;
    logic            resp_err_s;
    logic [31:0]     resp_rdata_s;

    // Arbitration: on a tie the master that was not granted last wins.
    always_comb begin
        any_req_s = m0_ready | m1_ready;
        if (m0_ready && m1_ready) begin
            winner_s = ~owner;
        end else if (m1_ready) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        if (winner_s) begin
            win_addr_s  = m1_addr;
            win_wdata_s = m1_wdata;
            win_wstrb_s = m1_wstrb;
        end else begin
            win_addr_s  = m0_addr;
            win_wdata_s = m0_wdata;
            win_wstrb_s = m0_wstrb;
        end
        addr_ok_s = (win_addr_s < MEM_LIMIT);
        timeout_s = (timer_r == TIMER_LAST);
    end

    // State register plus the latched memory request, owner and watchdog timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            owner     <= 1'b1;
            mem_ready <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            timer_r   <= '0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner     <= winner_s;
                        mem_addr  <= win_addr_s;
                        mem_wdata <= win_wdata_s;
                        mem_wstrb <= win_wstrb_s;
                        mem_ready <= addr_ok_s;
                        timer_r   <= '0;
                    end
                end
                BUSY: begin
                    // A response in the timeout cycle still counts as a normal completion.
                    if (mem_valid || timeout_s) begin
                        mem_ready <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ERR:     mem_ready <= 1'b0;
                default: mem_ready <= 1'b0;
            endcase
        end
    end

    // Next-state decision.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = addr_ok_s ? BUSY : ERR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_valid) begin
                    next_state_s = IDLE;
                end else if (timeout_s) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = BUSY;
                end
            end
            ERR:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Response steering; mem_valid outside BUSY is ignored.
    always_comb begin
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'd0;
        case (state_r)
            BUSY: begin
                if (mem_valid) begin
                    resp_valid_s = 1'b1;
                    resp_rdata_s = mem_rdata;
                end else begin
                    resp_valid_s = 1'b0;
                end
            end
            ERR: begin
                resp_valid_s = 1'b1;
                resp_err_s   = 1'b1;
            end
            default: resp_valid_s = 1'b0;
        endcase
        m0_valid = resp_valid_s & ~owner;
        m0_err   = resp_err_s & ~owner;
        m0_rdata = owner ? 32'd0 : resp_rdata_s;
        m1_valid = resp_valid_s & owner;
        m1_err   = resp_err_s & owner;
        m1_rdata = owner ? resp_rdata_s : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
// The model can be stalled or can inject a stray response.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_valid, m1_valid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        owner;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    logic        mem_valid_q, inject, stall, mem_init;
    logic [31:0] mem_rdata_q, inject_data;

    mem_arbiter #(.MEM_BYTES(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_valid(m0_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_valid(m1_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_valid = mem_valid_q | inject;
    assign mem_rdata = inject ? inject_data : mem_rdata_q;

    // Memory model: accepts mem_ready at an edge and answers with a pulse in the following cycle.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[255]    <= 32'd5;
            mem[4]      <= 32'h1122_3344;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= 32'd0;
        end else if (mem_ready && !mem_valid_q && !stall) begin
            mem_valid_q <= 1'b1;
            if (mem_wstrb == 4'd0) begin
                mem_rdata_q <= mem[mem_addr[9:2]];
            end else begin
                mem_rdata_q <= 32'd0;
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end else begin
            mem_valid_q <= 1'b0;
            mem_rdata_q <= 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic rdy, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (m) begin
            m1_ready = rdy; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_ready = rdy; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    // One transaction by a single master, checking latency, response and the request side.
    task automatic txn(input logic m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input string name);
        logic got;
        logic own_v, oth_v, own_e;
        logic [31:0] own_d;
        got = 1'b0;
        @(negedge clk);
        drive(m, 1'b1, a, wd, ws);
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            own_v = m ? m1_valid : m0_valid;
            oth_v = m ? m0_valid : m1_valid;
            own_e = m ? m1_err : m0_err;
            own_d = m ? m1_rdata : m0_rdata;
            chk({name, "_other_valid"}, 32'(oth_v), 32'd0);
            if (c == 1) begin
                chk({name, "_mem_ready"}, 32'(mem_ready), 32'(!exp_err));
                chk({name, "_mem_addr"}, mem_addr, a);
                chk({name, "_owner"}, 32'(owner), 32'(m));
                if (!exp_err) chk({name, "_mem_wstrb"}, 32'(mem_wstrb), 32'(ws));
            end
            if (own_v) begin
                got = 1'b1;
                chk({name, "_latency"}, 32'(c), 32'(exp_lat));
                chk({name, "_rdata"}, own_d, exp_rd);
                chk({name, "_err"}, 32'(own_e), 32'(exp_err));
                drive(m, 1'b0, a, wd, ws);
            end
        end
        chk({name, "_resp_seen"}, 32'(got), 32'd1);
        drive(m, 1'b0, a, wd, ws);
        @(negedge clk);
        chk({name, "_pulse_end"}, 32'(m ? m1_valid : m0_valid), 32'd0);
    endtask

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] exp_rd_rr [3];
        int          exp_c_rr  [3];
        logic        exp_m_rr  [3];
        int          got_n;
        int          ready_cycles;
        logic        got;

        vecs[0] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'h0000_0005, 1'b0, 2};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 32'h0,         1'b0, 2};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'h0,         4'b0000, 32'h1122_CCDD, 1'b0, 2};
        vecs[3] = '{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 32'h0,         1'b1, 1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0,         1'b1, 1};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 4'b1111, 32'h0,         1'b0, 2};
        vecs[6] = '{1'b0, 32'h0000_0002, 32'h0,         4'b0000, 32'h1234_5678, 1'b0, 2};
        vecs[7] = '{1'b1, 32'h0000_03FF, 32'h0,         4'b0000, 32'h0000_0005, 1'b0, 2};
        vecs[8] = '{1'b0, 32'h0000_03FC, 32'hDEAD_BEEF, 4'b1100, 32'h0,         1'b0, 2};
        vecs[9] = '{1'b1, 32'h0000_03FC, 32'h0,         4'b0000, 32'hDEAD_0005, 1'b0, 2};

        reset = 1'b0; mem_init = 1'b1; stall = 1'b0; inject = 1'b0; inject_data = 32'd0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; mem_init = 1'b0;
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_m0_valid", 32'(m0_valid), 32'd0);
        chk("rst_m1_valid", 32'(m1_valid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);

        for (int i = 0; i < 10; i++)
            txn(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].rdata, vecs[i].err, vecs[i].lat, $sformatf("v%0d", i));
        chk("mem4_after_write", mem[4], 32'h1122_CCDD);

        // Both masters held: grants alternate starting with m0, one every three cycles.
        exp_m_rr  = '{1'b0, 1'b1, 1'b0};
        exp_c_rr  = '{2, 5, 8};
        exp_rd_rr = '{32'hDEAD_0005, 32'h1234_5678, 32'hDEAD_0005};
        got_n = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h3FC, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 32'h000, 32'd0, 4'd0);
        for (int c = 1; c <= 20 && got_n < 3; c++) begin
            @(negedge clk);
            if (m0_valid || m1_valid) begin
                chk($sformatf("rr%0d_both", got_n), 32'(m0_valid & m1_valid), 32'd0);
                chk($sformatf("rr%0d_master", got_n), 32'(m1_valid), 32'(exp_m_rr[got_n]));
                chk($sformatf("rr%0d_cycle", got_n), 32'(c), 32'(exp_c_rr[got_n]));
                chk($sformatf("rr%0d_owner", got_n), 32'(owner), 32'(exp_m_rr[got_n]));
                chk($sformatf("rr%0d_rdata", got_n), m1_valid ? m1_rdata : m0_rdata, exp_rd_rr[got_n]);
                got_n++;
                if (got_n == 3) begin
                    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
                    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
                end
            end
        end
        chk("rr_count", 32'(got_n), 32'd3);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("rr_quiet", 32'(m0_valid | m1_valid), 32'd0);

        // Stalled memory: watchdog error after 16 BUSY cycles, then a stray response is dropped.
        stall = 1'b1;
        ready_cycles = 0;
        got = 1'b0;
        drive(1'b0, 1'b1, 32'h8, 32'd0, 4'd0);
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (mem_ready) ready_cycles++;
            if (m0_valid) begin
                got = 1'b1;
                chk("to_cycle", 32'(c), 32'd17);
                chk("to_err", 32'(m0_err), 32'd1);
                chk("to_rdata", m0_rdata, 32'd0);
                chk("to_mem_ready", 32'(mem_ready), 32'd0);
                drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            end
        end
        chk("to_resp_seen", 32'(got), 32'd1);
        chk("to_busy_cycles", 32'(ready_cycles), 32'd16);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        stall = 1'b0; inject = 1'b1; inject_data = 32'h5A5A_5A5A;
        #2;
        chk("late_m0_valid", 32'(m0_valid), 32'd0);
        chk("late_m1_valid", 32'(m1_valid), 32'd0);
        chk("late_m0_rdata", m0_rdata, 32'd0);
        @(negedge clk);
        inject = 1'b0;

        // Reset while BUSY: transaction abandoned, memory's answer not forwarded.
        drive(1'b0, 1'b1, 32'h0, 32'd0, 4'd0);
        @(negedge clk);
        chk("rb_busy_ready", 32'(mem_ready), 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rb_mem_ready", 32'(mem_ready), 32'd0);
        chk("rb_owner", 32'(owner), 32'd1);
        chk("rb_m0_valid", 32'(m0_valid), 32'd0);
        chk("rb_m1_valid", 32'(m1_valid), 32'd0);
        txn(1'b1, 32'h3FC, 32'd0, 4'd0, 32'hDEAD_0005, 1'b0, 2, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
